// File: rtl/tmr_status_pkg.sv
// Shared definitions for the TMR status/LED output block: display mode codes
// and the supervisory FSM state type.
package tmr_status_pkg;

  localparam logic [1:0] MODE_TIME  = 2'd0;
  localparam logic [1:0] MODE_FAULT = 2'd1;
  localparam logic [1:0] MODE_WALK  = 2'd2;
  localparam logic [1:0] MODE_OFF   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

endpackage

// File: rtl/tmr_fault_counter.sv
// One voter channel: rising-edge detect, sticky fault flag, registered LED bit
// and (with TMR_STATUS_FAULT_CNT_EN defined) a saturating edge counter.
module tmr_fault_counter #(
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flag,
  input  logic              i_clear,
  output logic              o_rise,
  output logic              o_sticky_nxt,
  output logic              o_led,
  output logic [FCNT_W-1:0] o_count
);

  logic r_prev;
  logic r_sticky;
  logic r_led;

  assign o_rise = i_flag & ~r_prev;

  // Clear wins over a coincident edge; the edge history still advances so the
  // suppressed edge is never counted later.
  always_comb begin
    o_sticky_nxt = r_sticky | o_rise;
    if (i_clear) begin
      o_sticky_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev   <= 1'b0;
      r_sticky <= 1'b0;
      r_led    <= 1'b0;
    end else begin
      r_prev   <= i_flag;
      r_sticky <= o_sticky_nxt;
      r_led    <= i_flag | o_sticky_nxt;
    end
  end

  assign o_led = r_led;

`ifdef TMR_STATUS_FAULT_CNT_EN
  logic [FCNT_W-1:0] r_count;

  function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (o_rise) begin
      r_count <= sat_inc(r_count);
    end
  end

  assign o_count = r_count;
`else
  assign o_count = '0;
`endif

endmodule

// File: rtl/tmr_status_outputs.sv
// TMR status outputs: IDLE/RUN/ALARM supervisor, LED display modes and
// per-channel fault tracking. Optional counters: TMR_STATUS_FAULT_CNT_EN.
module tmr_status_outputs
  import tmr_status_pkg::*;
#(
  parameter int TIME_W    = 64,
  parameter int LED_W     = 8,
  parameter int LED_LSB   = 24,
  parameter int BLINK_BIT = 25,
  parameter int NCH       = 3,
  parameter int FCNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  voted_resetn,
  input  logic [TIME_W-1:0]     voted_time_count,
  input  logic                  disagreement,
  input  logic [NCH-1:0]        fault_flags,
  input  logic [1:0]            mode,
  input  logic                  clear_faults,
  output logic [LED_W-1:0]      led_pattern,
  output logic                  status_led,
  output logic                  disagree_led,
  output logic [NCH-1:0]        fault_leds,
  output logic [NCH*FCNT_W-1:0] fault_count,
  output logic                  alarm
);

  localparam int WALK_W = (LED_W > 1) ? $clog2(LED_W) : 1;
  localparam logic [WALK_W-1:0] WALK_LAST = WALK_W'(LED_W - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic               r_dis_prev;
  logic               r_blink_prev;
  logic               r_walk_active;
  logic [WALK_W-1:0]  r_walk_pos;
  logic [LED_W-1:0]   r_led_pattern;
  logic               r_status_led;
  logic               r_disagree_led;
  logic               r_alarm;

  logic [NCH-1:0]       w_rise;
  logic [NCH-1:0]       w_sticky_nxt;
  logic                 w_dis_rise;
  logic                 w_blink;
  logic                 w_toggle;
  logic                 w_walk_active;
  logic [WALK_W-1:0]    w_walk_pos_nxt;
  logic [NCH+LED_W-1:0] w_fault_pad;
  logic [LED_W-1:0]     w_led_nxt;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tmr_fault_counter #(
      .FCNT_W(FCNT_W)
    ) u_cnt (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_flag       (fault_flags[g]),
      .i_clear      (clear_faults),
      .o_rise       (w_rise[g]),
      .o_sticky_nxt (w_sticky_nxt[g]),
      .o_led        (fault_leds[g]),
      .o_count      (fault_count[g*FCNT_W +: FCNT_W])
    );
  end

  assign w_dis_rise  = disagreement & ~r_dis_prev;
  assign w_blink     = voted_time_count[BLINK_BIT];
  assign w_toggle    = w_blink ^ r_blink_prev;
  assign w_fault_pad = {{LED_W{1'b0}}, w_sticky_nxt};

  always_comb begin
    w_state_nxt = r_state;
    if (!voted_resetn) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   if ((|w_rise) || w_dis_rise) w_state_nxt = ST_ALARM;
        ST_ALARM: if (clear_faults && (fault_flags == '0) && !disagreement)
                    w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Walk restarts at bit 0 whenever it becomes the visible mode, including
  // when leaving IDLE with WALK already selected.
  always_comb begin
    w_walk_active  = (w_state_nxt != ST_IDLE) && (mode == MODE_WALK);
    w_walk_pos_nxt = r_walk_pos;
    if (w_walk_active) begin
      if (!r_walk_active) begin
        w_walk_pos_nxt = '0;
      end else if (w_toggle) begin
        w_walk_pos_nxt = (r_walk_pos == WALK_LAST) ? '0 : r_walk_pos + 1'b1;
      end
    end
  end

  always_comb begin
    w_led_nxt = '0;
    if (w_state_nxt != ST_IDLE) begin
      case (mode)
        MODE_TIME:  w_led_nxt = voted_time_count[LED_LSB +: LED_W];
        MODE_FAULT: w_led_nxt = w_fault_pad[LED_W-1:0];
        MODE_WALK:  w_led_nxt[w_walk_pos_nxt] = 1'b1;
        default:    w_led_nxt = '0;
      endcase
    end
  end

  // Output registers are loaded from the next state so FSM-derived outputs
  // show the state being entered on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_dis_prev     <= 1'b0;
      r_blink_prev   <= 1'b0;
      r_walk_active  <= 1'b0;
      r_walk_pos     <= '0;
      r_led_pattern  <= '0;
      r_status_led   <= 1'b0;
      r_disagree_led <= 1'b0;
      r_alarm        <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_dis_prev     <= disagreement;
      r_blink_prev   <= w_blink;
      r_walk_active  <= w_walk_active;
      r_walk_pos     <= w_walk_pos_nxt;
      r_led_pattern  <= w_led_nxt;
      r_status_led   <= (w_state_nxt != ST_IDLE) & w_blink;
      r_disagree_led <= (w_state_nxt == ST_ALARM) ? w_blink : disagreement;
      r_alarm        <= (w_state_nxt == ST_ALARM);
    end
  end

  assign led_pattern  = r_led_pattern;
  assign status_led   = r_status_led;
  assign disagree_led = r_disagree_led;
  assign alarm        = r_alarm;

endmodule

// File: tb/tb_tmr_status_outputs.sv
// Bench for tmr_status_outputs: vector table, directed corner sequences and
// randomized traffic against a behavioural model.
module tb_tmr_status_outputs;

`ifdef TMR_STATUS_FAULT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [63:0] T0 = 64'h0;
  localparam logic [63:0] TA = 64'h0000_0000_A500_0000;
  localparam logic [63:0] TB = 64'h0000_0000_0200_0000;
  localparam logic [63:0] TF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [23:0] C1 = 24'h00_01_00;

  logic        clk;
  logic        rst_n;
  logic        voted_resetn;
  logic [63:0] voted_time_count;
  logic        disagreement;
  logic [2:0]  fault_flags;
  logic [1:0]  mode;
  logic        clear_faults;
  logic [7:0]  led_pattern;
  logic        status_led;
  logic        disagree_led;
  logic [2:0]  fault_leds;
  logic [23:0] fault_count;
  logic        alarm;

  int n_checks = 0;
  int n_fail   = 0;

  tmr_status_outputs #(
    .TIME_W(64), .LED_W(8), .LED_LSB(24), .BLINK_BIT(25), .NCH(3), .FCNT_W(8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .voted_resetn     (voted_resetn),
    .voted_time_count (voted_time_count),
    .disagreement     (disagreement),
    .fault_flags      (fault_flags),
    .mode             (mode),
    .clear_faults     (clear_faults),
    .led_pattern      (led_pattern),
    .status_led       (status_led),
    .disagree_led     (disagree_led),
    .fault_leds       (fault_leds),
    .fault_count      (fault_count),
    .alarm            (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: state as plain ints, counts as integers clipped at 255.
  int   m_state;
  bit   m_prev_f[3];
  bit   m_prev_dis;
  bit   m_sticky[3];
  int   m_cnt[3];
  bit   m_blink_prev;
  bit   m_walk_on;
  int   m_walk_pos;
  logic [7:0]  e_led;
  logic        e_status, e_dis, e_alarm;
  logic [2:0]  e_fleds;
  logic [23:0] e_count;

  task automatic model_step();
    bit any_rise, dis_rise, blink, toggled, walk_now;
    any_rise = 1'b0;
    if (!rst_n) begin
      m_state = 0; m_prev_dis = 0; m_blink_prev = 0; m_walk_on = 0; m_walk_pos = 0;
      for (int i = 0; i < 3; i++) begin
        m_prev_f[i] = 0; m_sticky[i] = 0; m_cnt[i] = 0;
      end
      e_led = '0; e_status = 0; e_dis = 0; e_alarm = 0; e_fleds = '0; e_count = '0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      bit r;
      r = fault_flags[i] && !m_prev_f[i];
      if (r) any_rise = 1'b1;
      if (clear_faults) begin
        m_sticky[i] = 0; m_cnt[i] = 0;
      end else if (r) begin
        m_sticky[i] = 1;
        if (m_cnt[i] < 255) m_cnt[i]++;
      end
      m_prev_f[i] = fault_flags[i];
    end
    dis_rise = disagreement && !m_prev_dis;
    m_prev_dis = disagreement;
    if (!voted_resetn) m_state = 0;
    else if (m_state == 0) m_state = 1;
    else if (m_state == 1 && (any_rise || dis_rise)) m_state = 2;
    else if (m_state == 2 && clear_faults && fault_flags == 3'b000 && !disagreement) m_state = 1;
    blink = voted_time_count[25];
    toggled = (blink != m_blink_prev);
    m_blink_prev = blink;
    walk_now = (m_state != 0) && (mode == 2'd2);
    if (walk_now) begin
      if (!m_walk_on) m_walk_pos = 0;
      else if (toggled) m_walk_pos = (m_walk_pos + 1) % 8;
    end
    m_walk_on = walk_now;
    e_alarm  = (m_state == 2);
    e_status = (m_state != 0) && blink;
    e_dis    = (m_state == 2) ? blink : disagreement;
    e_led    = '0;
    if (m_state != 0) begin
      case (mode)
        2'd0: e_led = 8'((voted_time_count >> 24) & 64'hFF);
        2'd1: e_led = {5'b0, m_sticky[2], m_sticky[1], m_sticky[0]};
        2'd2: e_led = 8'(1 << m_walk_pos);
        default: e_led = '0;
      endcase
    end
    for (int i = 0; i < 3; i++) begin
      e_fleds[i] = fault_flags[i] | m_sticky[i];
      e_count[i*8 +: 8] = CNT_EN ? 8'(m_cnt[i]) : 8'h00;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " led_pattern"}, 64'(led_pattern), 64'(e_led));
    chk({tag, " status_led"}, 64'(status_led), 64'(e_status));
    chk({tag, " disagree_led"}, 64'(disagree_led), 64'(e_dis));
    chk({tag, " fault_leds"}, 64'(fault_leds), 64'(e_fleds));
    chk({tag, " fault_count"}, 64'(fault_count), 64'(e_count));
    chk({tag, " alarm"}, 64'(alarm), 64'(e_alarm));
  endtask

  task automatic set_in(input bit r, input bit v, input logic [63:0] t, input bit d,
                        input logic [2:0] f, input logic [1:0] m, input bit c);
    rst_n = r; voted_resetn = v; voted_time_count = t; disagreement = d;
    fault_flags = f; mode = m; clear_faults = c;
  endtask

  typedef struct {
    bit          rst_n;
    bit          vres;
    logic [63:0] tm;
    bit          dis;
    logic [2:0]  fl;
    logic [1:0]  md;
    bit          clr;
    logic [7:0]  led;
    bit          st;
    bit          dl;
    logic [2:0]  fled;
    bit          al;
    logic [23:0] cnt;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{0, 1, TF, 1, 3'b111, 2'd0, 1, 8'h00, 0, 0, 3'b000, 0, 24'h0};
    tbl[1]  = '{0, 1, TF, 1, 3'b111, 2'd0, 1, 8'h00, 0, 0, 3'b000, 0, 24'h0};
    tbl[2]  = '{1, 0, T0, 0, 3'b000, 2'd0, 0, 8'h00, 0, 0, 3'b000, 0, 24'h0};
    tbl[3]  = '{1, 1, TA, 0, 3'b000, 2'd0, 0, 8'hA5, 0, 0, 3'b000, 0, 24'h0};
    tbl[4]  = '{1, 1, TB, 0, 3'b000, 2'd0, 0, 8'h02, 1, 0, 3'b000, 0, 24'h0};
    tbl[5]  = '{1, 1, TA, 0, 3'b010, 2'd0, 0, 8'hA5, 0, 0, 3'b010, 1, C1};
    tbl[6]  = '{1, 1, TB, 0, 3'b010, 2'd0, 0, 8'h02, 1, 1, 3'b010, 1, C1};
    tbl[7]  = '{1, 1, T0, 0, 3'b010, 2'd0, 0, 8'h00, 0, 0, 3'b010, 1, C1};
    tbl[8]  = '{1, 1, T0, 0, 3'b010, 2'd0, 0, 8'h00, 0, 0, 3'b010, 1, C1};
    tbl[9]  = '{1, 1, T0, 0, 3'b010, 2'd0, 0, 8'h00, 0, 0, 3'b010, 1, C1};
    tbl[10] = '{1, 1, T0, 0, 3'b000, 2'd1, 0, 8'h02, 0, 0, 3'b010, 1, C1};
    tbl[11] = '{1, 1, T0, 0, 3'b000, 2'd2, 0, 8'h01, 0, 0, 3'b010, 1, C1};
    tbl[12] = '{1, 1, TB, 0, 3'b000, 2'd2, 0, 8'h02, 1, 1, 3'b010, 1, C1};
    tbl[13] = '{1, 1, TB, 0, 3'b000, 2'd2, 0, 8'h02, 1, 1, 3'b010, 1, C1};
    tbl[14] = '{1, 1, T0, 0, 3'b000, 2'd2, 0, 8'h04, 0, 0, 3'b010, 1, C1};
    tbl[15] = '{1, 1, T0, 0, 3'b000, 2'd3, 1, 8'h00, 0, 0, 3'b000, 0, 24'h0};
    tbl[16] = '{1, 1, T0, 1, 3'b000, 2'd0, 0, 8'h00, 0, 0, 3'b000, 1, 24'h0};
    tbl[17] = '{1, 1, TB, 1, 3'b000, 2'd0, 1, 8'h02, 1, 1, 3'b000, 1, 24'h0};
    tbl[18] = '{1, 1, T0, 0, 3'b000, 2'd0, 1, 8'h00, 0, 0, 3'b000, 0, 24'h0};
    tbl[19] = '{1, 0, TA, 1, 3'b000, 2'd0, 0, 8'h00, 0, 1, 3'b000, 0, 24'h0};

    set_in(0, 1, TF, 1, 3'b111, 2'd0, 1);

    // Vector table: reset, TIME, fault alarm, FAULT/WALK display, clear, idle.
    for (int r = 0; r < 20; r++) begin
      string tag;
      tag = $sformatf("vec%0d", r);
      set_in(tbl[r].rst_n, tbl[r].vres, tbl[r].tm, tbl[r].dis, tbl[r].fl, tbl[r].md, tbl[r].clr);
      step();
      chk({tag, " led_pattern"}, 64'(led_pattern), 64'(tbl[r].led));
      chk({tag, " status_led"}, 64'(status_led), 64'(tbl[r].st));
      chk({tag, " disagree_led"}, 64'(disagree_led), 64'(tbl[r].dl));
      chk({tag, " fault_leds"}, 64'(fault_leds), 64'(tbl[r].fled));
      chk({tag, " alarm"}, 64'(alarm), 64'(tbl[r].al));
      chk({tag, " fault_count"}, 64'(fault_count), CNT_EN ? 64'(tbl[r].cnt) : 64'h0);
    end

    // Saturation on channel 0.
    set_in(1, 1, T0, 0, 3'b000, 2'd0, 0);
    for (int k = 0; k < 254; k++) begin
      fault_flags = 3'b001; step();
      fault_flags = 3'b000; step();
    end
    chk("sat254 count0", 64'(fault_count[7:0]), CNT_EN ? 64'hFE : 64'h0);
    chk("sat254 alarm", 64'(alarm), 64'h1);
    for (int k = 0; k < 46; k++) begin
      fault_flags = 3'b001; step();
      fault_flags = 3'b000; step();
    end
    chk("sat300 count0", 64'(fault_count[7:0]), CNT_EN ? 64'hFF : 64'h0);

    // Clear collides with a channel 2 rising edge.
    set_in(1, 1, T0, 0, 3'b000, 2'd1, 1); step();
    chk("clr0 alarm", 64'(alarm), 64'h0);
    chk("clr0 count", 64'(fault_count), 64'h0);
    fault_flags = 3'b100; clear_faults = 1; step();
    chk("coll count", 64'(fault_count), 64'h0);
    chk("coll sticky_led", 64'(led_pattern), 64'h0);
    chk("coll fault_leds", 64'(fault_leds), 64'h4);
    chk("coll alarm", 64'(alarm), 64'h1);
    step();
    chk("coll hold alarm", 64'(alarm), 64'h1);
    clear_faults = 0; step();
    chk("coll no late count", 64'(fault_count), 64'h0);
    fault_flags = 3'b000; step();
    chk("coll sticky clear", 64'(fault_leds), 64'h0);
    chk("coll alarm kept", 64'(alarm), 64'h1);
    clear_faults = 1; step();
    chk("coll back to run", 64'(alarm), 64'h0);

    // Dropping voted_resetn while in ALARM.
    set_in(1, 1, TA, 0, 3'b010, 2'd0, 0); step();
    chk("idle pre alarm", 64'(alarm), 64'h1);
    fault_flags = 3'b000; step();
    voted_resetn = 0; step();
    chk("idle alarm", 64'(alarm), 64'h0);
    chk("idle led", 64'(led_pattern), 64'h0);
    chk("idle status", 64'(status_led), 64'h0);
    chk("idle count kept", 64'(fault_count), CNT_EN ? 64'(C1) : 64'h0);

    // Randomized traffic against the model.
    set_in(0, 1, T0, 0, 3'b000, 2'd0, 0);
    step(); step();
    check_model("rnd reset");
    rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      voted_resetn = ($urandom_range(0, 59) != 0);
      voted_time_count = voted_time_count + 64'($urandom_range(0, 32'h0300_0000));
      if ($urandom_range(0, 3) == 0) fault_flags = 3'($urandom);
      if ($urandom_range(0, 7) == 0) fault_flags = 3'b000;
      if ($urandom_range(0, 7) == 0) disagreement = ~disagreement;
      clear_faults = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      step();
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
